// File: rtl/stage_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_wb_if
// Description : MEM->WB handshake bundle plus WB-side result outputs
//               (register-file port, forwarding source, architectural state).
// Revision    : 1.0  initial release
// ============================================================================
interface stage_wb_if #(
  parameter int WORD_SIZE  = 16,
  parameter int REG_ADDR_W = 2
);
  // Pipeline control and MEM stage outputs
  logic                  freeze;
  logic                  bubble;
  logic                  in_valid;
  logic [WORD_SIZE-1:0]  in_alu_result;
  logic [WORD_SIZE-1:0]  in_read_data;
  logic                  in_mem_to_reg;
  logic                  in_reg_write;
  logic [REG_ADDR_W-1:0] in_dest;
  logic                  in_is_wwd;
  logic                  in_is_halt;

  // Write-back results
  logic                  rf_write;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [WORD_SIZE-1:0]  rf_data;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [WORD_SIZE-1:0]  fwd_data;
  logic [WORD_SIZE-1:0]  output_port;
  logic                  is_halted;
  logic [WORD_SIZE-1:0]  num_inst;

  modport master (
    output freeze, bubble, in_valid, in_alu_result, in_read_data,
           in_mem_to_reg, in_reg_write, in_dest, in_is_wwd, in_is_halt,
    input  rf_write, rf_addr, rf_data, fwd_valid, fwd_addr, fwd_data,
           output_port, is_halted, num_inst
  );

  modport slave (
    input  freeze, bubble, in_valid, in_alu_result, in_read_data,
           in_mem_to_reg, in_reg_write, in_dest, in_is_wwd, in_is_halt,
    output rf_write, rf_addr, rf_data, fwd_valid, fwd_addr, fwd_data,
           output_port, is_halted, num_inst
  );
endinterface
`default_nettype wire

// File: rtl/stage_wb.sv
`default_nettype none
// ============================================================================
// Module      : stage_wb
// Description : Write-back stage: MEM/WB register, write-back mux, register
//               file / forwarding drive, WWD port, HLT latch, retired count.
//               Optional macro WB_INST_COUNT_EN enables the num_inst counter.
// Revision    : 1.0  initial release
// ============================================================================
module stage_wb #(
  parameter int WORD_SIZE  = 16,
  parameter int REG_ADDR_W = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  stage_wb_if.slave      wb
);

  // MEM/WB pipeline register
  logic                  wb_valid_q,   wb_valid_d;
  logic [WORD_SIZE-1:0]  alu_q,        alu_d;
  logic [WORD_SIZE-1:0]  rdata_q,      rdata_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  reg_write_q,  reg_write_d;
  logic [REG_ADDR_W-1:0] dest_q,       dest_d;
  logic                  is_wwd_q,     is_wwd_d;
  logic                  is_halt_q,    is_halt_d;
  logic                  done_q,       done_d;

  // Architectural side-effect state
  logic [WORD_SIZE-1:0]  output_port_q, output_port_d;
  logic                  halted_q,      halted_d;

  logic [WORD_SIZE-1:0]  wb_value;
  logic                  capture;
  logic                  squash;

  assign squash  = halted_q | wb.bubble;
  assign capture = !squash && !wb.freeze;

  always_comb begin
    wb_valid_d   = wb_valid_q;
    alu_d        = alu_q;
    rdata_d      = rdata_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    dest_d       = dest_q;
    is_wwd_d     = is_wwd_q;
    is_halt_d    = is_halt_q;
    done_d       = done_q;

    if (squash) begin
      wb_valid_d   = 1'b0;
      alu_d        = '0;
      rdata_d      = '0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      dest_d       = '0;
      is_wwd_d     = 1'b0;
      is_halt_d    = 1'b0;
      done_d       = 1'b0;
    end else if (wb.freeze) begin
      // Entry has had its one write opportunity; suppress repeats while held.
      done_d       = done_q | wb_valid_q;
    end else begin
      wb_valid_d   = wb.in_valid;
      alu_d        = wb.in_alu_result;
      rdata_d      = wb.in_read_data;
      mem_to_reg_d = wb.in_mem_to_reg;
      reg_write_d  = wb.in_reg_write;
      dest_d       = wb.in_dest;
      is_wwd_d     = wb.in_is_wwd;
      is_halt_d    = wb.in_is_halt;
      done_d       = 1'b0;
    end
  end

  always_comb begin
    output_port_d = output_port_q;
    if (wb_valid_q && is_wwd_q && !done_q && !halted_q) begin
      output_port_d = alu_q;
    end
    halted_d = halted_q | (wb_valid_q & is_halt_q);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      wb_valid_q    <= 1'b0;
      alu_q         <= '0;
      rdata_q       <= '0;
      mem_to_reg_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      dest_q        <= '0;
      is_wwd_q      <= 1'b0;
      is_halt_q     <= 1'b0;
      done_q        <= 1'b0;
      output_port_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      alu_q         <= alu_d;
      rdata_q       <= rdata_d;
      mem_to_reg_q  <= mem_to_reg_d;
      reg_write_q   <= reg_write_d;
      dest_q        <= dest_d;
      is_wwd_q      <= is_wwd_d;
      is_halt_q     <= is_halt_d;
      done_q        <= done_d;
      output_port_q <= output_port_d;
      halted_q      <= halted_d;
    end
  end

  assign wb_value = mem_to_reg_q ? rdata_q : alu_q;

  assign wb.rf_write    = wb_valid_q & reg_write_q & !done_q & !halted_q;
  assign wb.rf_addr     = dest_q;
  assign wb.rf_data     = wb_value;
  // A frozen entry remains the youngest producer, so it stays forwardable.
  assign wb.fwd_valid   = wb_valid_q & reg_write_q;
  assign wb.fwd_addr    = dest_q;
  assign wb.fwd_data    = wb_value;
  assign wb.output_port = output_port_q;
  assign wb.is_halted   = halted_q;

`ifdef WB_INST_COUNT_EN
  logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

  always_comb begin
    num_inst_d = num_inst_q;
    if (capture && wb.in_valid) begin
      num_inst_d = num_inst_q + WORD_SIZE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      num_inst_q <= '0;
    end else begin
      num_inst_q <= num_inst_d;
    end
  end

  assign wb.num_inst = num_inst_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign wb.num_inst    = '0;
`endif

endmodule
`default_nettype wire

// File: doc/stage_wb.md
# stage_wb

Write-back stage of the pipelined CPU, directly downstream of the MEM stage. It latches the MEM stage outputs into the MEM/WB pipeline register:
- load data taken from the MEM read data,
- ALU result,
- decoded write-back controls.

It selects the write-back value, drives the register-file write port and the forwarding source, and owns the architectural side effects: the WWD output port, HLT detection and the retired-instruction counter.

## Interface
Parameters:
- `WORD_SIZE`, 16, datapath width
- `REG_ADDR_W`, 2, register index width

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset_n`  in  1  synchronous, active-high reset (asserted = 1)
- `freeze`  in  1  pipeline-wide hold; MEM/WB register keeps its contents
- `bubble`  in  1  load an invalid entry instead of MEM outputs
- `in_valid`  in  1  MEM stage holds a real instruction
- `in_alu_result`  in  `WORD_SIZE`  address/ALU value passed through MEM
- `in_read_data`  in  `WORD_SIZE`  load data from MEM
- `in_mem_to_reg`  in  1  write-back selects load data
- `in_reg_write`  in  1  instruction writes a register
- `in_dest`  in  `REG_ADDR_W`  destination register
- `in_is_wwd`  in  1  instruction is WWD
- `in_is_halt`  in  1  instruction is HLT
- `rf_write`  out  1  register-file write enable
- `rf_addr`  out  `REG_ADDR_W`  write index
- `rf_data`  out  `WORD_SIZE`  write value
- `fwd_valid`  out  1  WB holds a valid register-writing entry
- `fwd_addr`  out  `REG_ADDR_W`  forwarding index
- `fwd_data`  out  `WORD_SIZE`  forwarding value
- `output_port`  out  `WORD_SIZE`  last WWD value
- `is_halted`  out  1  sticky halt flag
- `num_inst`  out  `WORD_SIZE`  count of instructions entered into WB

## Operation
- **MEM/WB register fields:** `wb_valid`, ALU result, load data, `mem_to_reg`, `reg_write`, dest, `is_wwd`, `is_halt`, plus a `done` flag.
- **Update priority each edge:** `reset_n` > `is_halted` > `bubble` > `freeze` > capture.
  - Reset or `bubble`: `wb_valid`=0, other fields 0.
  - Halted: register loads invalid every cycle.
  - `freeze`: all fields held.
  - Capture: fields load from `in_*`; `wb_valid`=`in_valid`; `done`=0.
- **`done` flag:**
  - Set on any edge where a valid entry is in WB and `freeze`=1.
  - Guarantees a frozen entry writes the register file and WWD port exactly once.
- **Write-back value:** `wb_value` = `mem_to_reg` ? load data : ALU result.
- **Register-file outputs:**
  - `rf_write` = `wb_valid` & `reg_write` & !`done` & !`is_halted`.
  - `rf_addr` = dest; `rf_data` = `wb_value`.
- **Forwarding outputs:**
  - `fwd_valid` = `wb_valid` & `reg_write`.
  - `fwd_valid` ignores `done`: a frozen entry stays forwardable.
  - `fwd_addr`/`fwd_data` mirror `rf_addr`/`rf_data`.
- **WWD:** on an edge where `wb_valid` & `is_wwd` & !`done`, `output_port` <= ALU result.
- **HLT:** on an edge where `wb_valid` & `is_halt`, `is_halted` <= 1. It stays 1 until reset.
- **Counter:**
  - `num_inst` increments by 1 on every capture edge with `in_valid`=1.
  - HLT is counted.
  - Wraps modulo 2^`WORD_SIZE`.
- **Reset values:** all register fields 0, `output_port`=0, `is_halted`=0, `num_inst`=0. Hence `rf_write`=0 and `fwd_valid`=0 after reset.

## Timing
- **Latency:** MEM outputs sampled at edge N drive `rf_*`/`fwd_*` combinationally during cycle N+1. The register file commits at edge N+1.
- **Output visibility:** `output_port` and `is_halted` change at edge N+1, visible in cycle N+2.
- **`bubble` with `freeze`:** `bubble` wins; the frozen entry is discarded.
- **Reset mid-freeze:** reset clears `done` and the entry; no pending write survives.
- **HLT entry:** still drives its own `rf_write`, normally 0. Any entry captured on the same edge that sets `is_halted` is replaced by invalid on the next edge and never writes.
- **Same-cycle forwarding:** forwarding outputs are purely combinational from the register. No same-cycle MEM-to-WB bypass exists inside this block.

## Configuration
- `WB_INST_COUNT_EN` defined: `num_inst` counter present as specified.
- `WB_INST_COUNT_EN` undefined: counter logic omitted; `num_inst` tied to 0. All other behaviour unchanged.

## Test plan
- **Load write-back:** capture `in_valid`=1, `mem_to_reg`=1, `reg_write`=1, dest=2, `read_data`=0x1234, `alu`=0x0040 -> next cycle `rf_write`=1, `rf_addr`=2, `rf_data`=0x1234, `fwd_valid`=1, `num_inst`=1.
- **Freeze:** ALU op (dest=1, `alu`=0x00FF) held by `freeze`=1 for 3 cycles -> `rf_write`=1 only in the first WB cycle. `fwd_valid`=1 all 4 cycles. `num_inst` increments once.
- **WWD:** WWD with `alu`=0xBEEF -> `output_port`=0xBEEF two cycles after capture. Under `freeze` it is written once; `rf_write`=0.
- **Bubble over freeze:** `bubble`=1 and `freeze`=1 together while a valid entry is held -> next cycle `wb_valid`=0, `rf_write`=0, `fwd_valid`=0.
- **HLT:** capture HLT then ALU op (dest=3) -> `is_halted`=1 and held. The ALU op never asserts `rf_write`. `num_inst`=2 with `WB_INST_COUNT_EN`, 0 without.
- **Reset and wrap:** `reset_n`=1 mid-freeze -> all outputs 0 next cycle. With `num_inst` preloaded to 0xFFFF via 65535 captures, one more capture -> 0x0000.
